// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one single-ported, variable-latency memory bus between
//               the core's instruction-fetch port and its data port.
//               Converts core read/write enables into a req/ack bus
//               transaction and returns one-cycle per-port ack pulses so
//               the pipeline stall logic can hold IF or MEM until the access
//               completes.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   inst_ren/inst_addr  fetch request (held until inst_ack) and address
//   inst_data/inst_ack  fetched word, one-cycle completion pulse
//   inst_stall          inst_ren & ~inst_ack (combinational)
//   mem_ren/mem_wen     data read / write request (held until mem_ack)
//   mem_addr/mem_dout   data address, write data from core
//   mem_din/mem_ack     read data to core, one-cycle completion pulse
//   mem_stall           (mem_ren | mem_wen) & ~mem_ack (combinational)
//   bus_req/bus_we      bus transaction active, 1=write
//   bus_addr/bus_wdata  bus address and write data
//   bus_ack/bus_rdata   completion from memory, read data valid with ack
//   bus_err             sticky: a transaction timed out
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_ren,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_data,
   output logic        inst_ack,
   output logic        inst_stall,

   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_ack,
   output logic        mem_stall,

   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam int                    c_STREAK_W   = $clog2(MAX_STREAK + 1);
   localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_STREAK);
   localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);
   // The timer is cleared on entry to BUSY, so it reads TIMEOUT-1 in the
   // TIMEOUT-th bus cycle; that is the last cycle the memory gets to answer.
   localparam logic [7:0]            c_TIMER_LAST = 8'(TIMEOUT - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [c_STREAK_W-1:0]   r_streak;
   logic [7:0]              r_timer;

   logic                    w_mem_req;
   logic                    w_force_fetch;
   logic                    w_grant_i;
   logic                    w_grant_d;
   logic                    w_busy;
   logic                    w_timeout;
   logic                    w_done;

   assign w_mem_req     = mem_ren | mem_wen;
   assign w_force_fetch = inst_ren && (r_streak == c_STREAK_MAX);
   assign w_busy        = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

   // Stall outputs are the only combinational outputs: the core needs them
   // in the same cycle it raises a request.
   assign inst_stall = inst_ren & ~inst_ack;
   assign mem_stall  = w_mem_req & ~mem_ack;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and grant decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_timeout   = 1'b0;
      w_done      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Data normally wins; a fetch that has waited out the streak
            // limit is forced through to keep IF from starving.
            if (inst_ren && (w_force_fetch || !w_mem_req)) begin
               w_grant_i   = 1'b1;
               w_state_nxt = ST_BUSY_I;
            end else if (w_mem_req) begin
               w_grant_d   = 1'b1;
               w_state_nxt = ST_BUSY_D;
            end
         end

         ST_BUSY_I, ST_BUSY_D: begin
            // An ack in the final allowed cycle still counts as a success.
            if (bus_ack) begin
               w_done = 1'b1;
            end else if (r_timer == c_TIMER_LAST) begin
               w_done    = 1'b1;
               w_timeout = 1'b1;
            end
            if (w_done) begin
               w_state_nxt = ST_RESP;
            end
         end

         // RESP gives the core one cycle to drop or change its request
         // before IDLE samples again, so a completed access is never
         // granted twice.
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bus, response and bookkeeping registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         bus_err   <= 1'b0;
         inst_data <= 32'h0;
         inst_ack  <= 1'b0;
         mem_din   <= 32'h0;
         mem_ack   <= 1'b0;
         r_streak  <= '0;
         r_timer   <= 8'h0;
      end else begin
         // Acks are single-cycle pulses by default.
         inst_ack <= 1'b0;
         mem_ack  <= 1'b0;

         if (w_grant_i) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= inst_addr;
            bus_wdata <= 32'h0;
            r_timer   <= 8'h0;
            r_streak  <= '0;
         end

         if (w_grant_d) begin
            bus_req   <= 1'b1;
            // A simultaneous read+write request is issued as a write.
            bus_we    <= mem_wen;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_dout;
            r_timer   <= 8'h0;
            // The streak only measures how long a pending fetch has been
            // passed over; with no fetch waiting it restarts.
            if (!inst_ren) begin
               r_streak <= '0;
            end else if (r_streak != c_STREAK_MAX) begin
               r_streak <= r_streak + c_STREAK_ONE;
            end
         end

         if (w_busy && !w_done) begin
            r_timer <= r_timer + 8'h1;
         end

         if (w_done) begin
            bus_req <= 1'b0;
            if (w_timeout) begin
               bus_err <= 1'b1;
            end
            if (r_state == ST_BUSY_I) begin
               inst_ack  <= 1'b1;
               inst_data <= w_timeout ? 32'h0 : bus_rdata;
            end else begin
               mem_ack <= 1'b1;
               // Writes leave the previous read data in place.
               if (!bus_we) begin
                  mem_din <= w_timeout ? 32'h0 : bus_rdata;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. A behavioural
//               memory answers bus requests after a programmable latency
//               (or never); expected completions are queued when requests
//               are driven and popped as the arbiter acknowledges them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        inst_ren;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        inst_ack;
   logic        inst_stall;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        mem_ack;
   logic        mem_stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack   = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_err;

   int n_checks = 0;
   int n_errors = 0;

   // memory model controls
   int mem_lat    = 1;
   bit mem_silent = 1'b0;
   bit stray_ack  = 1'b0;
   int lat_cnt    = 0;

   typedef struct {
      bit          is_data;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];

   mem_bus_arbiter #(
      .MAX_STREAK (4),
      .TIMEOUT    (255)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_ren   (inst_ren),
      .inst_addr  (inst_addr),
      .inst_data  (inst_data),
      .inst_ack   (inst_ack),
      .inst_stall (inst_stall),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_dout   (mem_dout),
      .mem_din    (mem_din),
      .mem_ack    (mem_ack),
      .mem_stall  (mem_stall),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata),
      .bus_err    (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h2402000A;
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   function automatic exp_t mk(input bit d, input bit w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd);
      exp_t e;
      e.is_data = d; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
      return e;
   endfunction

   function automatic logic [31:0] waddr(input int n);
      return 32'h300 + 32'(n) * 4;
   endfunction

   function automatic logic [31:0] wdat(input int n);
      return 32'hA000_0000 + 32'(n);
   endfunction

   // Behavioural memory: drives bus_ack/bus_rdata at the falling edge so the
   // arbiter samples them at the following rising edge.
   always @(negedge clk) begin
      if (stray_ack) begin
         bus_ack   = 1'b1;
         bus_rdata = 32'hBAD0_BAD0;
         lat_cnt   = 0;
      end else if (bus_req && !bus_ack && !mem_silent) begin
         lat_cnt = lat_cnt + 1;
         if (lat_cnt >= mem_lat) begin
            bus_ack   = 1'b1;
            bus_rdata = mem_word(bus_addr);
            lat_cnt   = 0;
         end
      end else begin
         bus_ack   = 1'b0;
         bus_rdata = 32'h0;
         if (!bus_req) lat_cnt = 0;
      end
   end

   task automatic apply_reset();
      rst = 1'b0;
      inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
      inst_addr = 32'h0; mem_addr = 32'h0; mem_dout = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
      inst_addr = 32'h0; mem_addr = 32'h0; mem_dout = 32'h0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus_req, bus_we, bus_err} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_ctrl: {req,we,err}=%b, expected 000", {bus_req, bus_we, bus_err});
      end
      n_checks++;
      if ({bus_addr, bus_wdata} !== 64'h0) begin
         n_errors++;
         $display("FAIL reset_bus: addr=%h wdata=%h, expected 0", bus_addr, bus_wdata);
      end
      n_checks++;
      if ({inst_ack, mem_ack} !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_ack: {inst_ack,mem_ack}=%b, expected 00", {inst_ack, mem_ack});
      end
      n_checks++;
      if ({inst_data, mem_din} !== 64'h0) begin
         n_errors++;
         $display("FAIL reset_data: inst_data=%h mem_din=%h, expected 0", inst_data, mem_din);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus_req, inst_stall, mem_stall} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_idle: {req,istall,mstall}=%b, expected 000", {bus_req, inst_stall, mem_stall});
      end
   endtask

   task automatic test_fetch_only();
      exp_t e;
      apply_reset();
      mem_silent = 1'b0; mem_lat = 1;
      sb.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, mem_word(32'h40)));
      inst_addr = 32'h40; inst_ren = 1'b1;           // cycle 0
      #1;
      n_checks++;
      if ({inst_stall, bus_req} !== 2'b10) begin
         n_errors++;
         $display("FAIL fetch_c0: {inst_stall,bus_req}=%b, expected 10", {inst_stall, bus_req});
      end
      @(negedge clk);                                // cycle 1
      n_checks++;
      if ({bus_req, bus_we, inst_ack} !== 3'b100 || bus_addr !== 32'h40) begin
         n_errors++;
         $display("FAIL fetch_c1: {req,we,ack}=%b addr=%h, expected 100 addr=00000040",
                  {bus_req, bus_we, inst_ack}, bus_addr);
      end
      @(negedge clk);                                // cycle 2
      e = sb.pop_front();
      n_checks++;
      if ({bus_req, inst_ack, inst_stall} !== 3'b010) begin
         n_errors++;
         $display("FAIL fetch_c2: {req,ack,stall}=%b, expected 010", {bus_req, inst_ack, inst_stall});
      end
      n_checks++;
      if (inst_data !== e.rdata) begin
         n_errors++;
         $display("FAIL fetch_data: inst_data=%h, expected %h", inst_data, e.rdata);
      end
      inst_ren = 1'b0;
      @(negedge clk);                                // cycle 3
      n_checks++;
      if ({inst_ack, bus_req} !== 2'b00) begin
         n_errors++;
         $display("FAIL fetch_c3: {ack,req}=%b, expected 00", {inst_ack, bus_req});
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      int   cyc;
      apply_reset();
      mem_silent = 1'b0; mem_lat = 2;
      sb.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, mem_word(32'h200)));
      sb.push_back(mk(1'b0, 1'b0, 32'h80,  32'h0, mem_word(32'h80)));
      inst_addr = 32'h80;  inst_ren = 1'b1;
      mem_addr  = 32'h200; mem_ren  = 1'b1; mem_wen = 1'b0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 40) begin
         @(negedge clk); cyc++;
         if (inst_ack || mem_ack) begin
            e = sb.pop_front();
            n_checks++;
            if ({inst_ack, mem_ack} !== {~e.is_data, e.is_data}) begin
               n_errors++;
               $display("FAIL sim_order: {inst_ack,mem_ack}=%b, expected %b",
                        {inst_ack, mem_ack}, {~e.is_data, e.is_data});
            end
            n_checks++;
            if (bus_addr !== e.addr) begin
               n_errors++;
               $display("FAIL sim_addr: bus_addr=%h, expected %h", bus_addr, e.addr);
            end
            n_checks++;
            if ((e.is_data ? mem_din : inst_data) !== e.rdata) begin
               n_errors++;
               $display("FAIL sim_data: data=%h, expected %h",
                        e.is_data ? mem_din : inst_data, e.rdata);
            end
            if (mem_ack) mem_ren = 1'b0;
            if (inst_ack) begin
               inst_ren = 1'b0;
               n_checks++;
               if (cyc !== 7) begin
                  n_errors++;
                  $display("FAIL sim_fetch_cycle: inst_ack at cycle %0d, expected 7", cyc);
               end
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL sim_timeout: %0d acks outstanding, expected 0", sb.size());
      end
      sb.delete();
      inst_ren = 1'b0; mem_ren = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_streak();
      exp_t e;
      int   wn, fn, cyc;
      apply_reset();
      mem_silent = 1'b0; mem_lat = 1;
      for (int n = 0; n < 4; n++) sb.push_back(mk(1'b1, 1'b1, waddr(n), wdat(n), 32'h0));
      sb.push_back(mk(1'b0, 1'b0, 32'h1000, 32'h0, mem_word(32'h1000)));
      for (int n = 4; n < 8; n++) sb.push_back(mk(1'b1, 1'b1, waddr(n), wdat(n), 32'h0));
      sb.push_back(mk(1'b0, 1'b0, 32'h1004, 32'h0, mem_word(32'h1004)));
      sb.push_back(mk(1'b1, 1'b1, waddr(8), wdat(8), 32'h0));
      wn = 0; fn = 0; cyc = 0;
      mem_wen = 1'b1; mem_ren = 1'b0; mem_addr = waddr(0); mem_dout = wdat(0);
      inst_ren = 1'b1; inst_addr = 32'h1000;
      while (sb.size() > 0 && cyc < 200) begin
         @(negedge clk); cyc++;
         if (mem_ack) begin
            e = sb.pop_front();
            n_checks++;
            if (e.is_data !== 1'b1 || {bus_we, bus_addr, bus_wdata} !== {1'b1, e.addr, e.wdata}) begin
               n_errors++;
               $display("FAIL streak_write: data_ack we=%b addr=%h wdata=%h, expected is_data=%b addr=%h wdata=%h",
                        bus_we, bus_addr, bus_wdata, e.is_data, e.addr, e.wdata);
            end
            n_checks++;
            if (mem_din !== 32'h0) begin
               n_errors++;
               $display("FAIL streak_din: mem_din=%h, expected 00000000", mem_din);
            end
            wn++;
            if (wn < 9) begin
               mem_addr = waddr(wn); mem_dout = wdat(wn);
            end else begin
               mem_wen = 1'b0;
            end
         end
         if (inst_ack) begin
            e = sb.pop_front();
            n_checks++;
            if (e.is_data !== 1'b0 || bus_addr !== e.addr || inst_data !== e.rdata) begin
               n_errors++;
               $display("FAIL streak_fetch: fetch_ack addr=%h data=%h, expected is_data=%b addr=%h data=%h",
                        bus_addr, inst_data, e.is_data, e.addr, e.rdata);
            end
            fn++;
            if (fn < 2) inst_addr = 32'h1004;
            else        inst_ren  = 1'b0;
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL streak_timeout: %0d acks outstanding, expected 0", sb.size());
      end
      sb.delete();
      inst_ren = 1'b0; mem_wen = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int req_cycles;
      bit got;
      apply_reset();
      mem_silent = 1'b0; mem_lat = 1;
      mem_ren = 1'b1; mem_addr = 32'h600;
      for (int i = 0; i < 10 && !mem_ack; i++) @(negedge clk);
      n_checks++;
      if (mem_ack !== 1'b1 || mem_din !== mem_word(32'h600) || bus_err !== 1'b0) begin
         n_errors++;
         $display("FAIL to_prime: ack=%b din=%h err=%b, expected 1 %h 0",
                  mem_ack, mem_din, bus_err, mem_word(32'h600));
      end
      mem_ren = 1'b0;
      @(negedge clk);
      mem_silent = 1'b1;
      mem_addr = 32'h500; mem_ren = 1'b1;
      req_cycles = 0; got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (bus_req) req_cycles++;
         if (mem_ack) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
         n_errors++;
         $display("FAIL to_no_ack: no mem_ack after 400 cycles, expected one");
      end
      n_checks++;
      if (req_cycles !== 255) begin
         n_errors++;
         $display("FAIL to_req_cycles: bus_req high %0d cycles, expected 255", req_cycles);
      end
      n_checks++;
      if ({bus_req, bus_err} !== 2'b01 || mem_din !== 32'h0) begin
         n_errors++;
         $display("FAIL to_resp: {req,err}=%b din=%h, expected 01 00000000", {bus_req, bus_err}, mem_din);
      end
      mem_ren = 1'b0; mem_silent = 1'b0;
      @(negedge clk);
      inst_addr = 32'h40; inst_ren = 1'b1;
      for (int i = 0; i < 10 && !inst_ack; i++) @(negedge clk);
      n_checks++;
      if (inst_ack !== 1'b1 || inst_data !== mem_word(32'h40) || bus_err !== 1'b1) begin
         n_errors++;
         $display("FAIL to_sticky: ack=%b data=%h err=%b, expected 1 %h 1",
                  inst_ack, inst_data, bus_err, mem_word(32'h40));
      end
      inst_ren = 1'b0;
      apply_reset();
      n_checks++;
      if (bus_err !== 1'b0) begin
         n_errors++;
         $display("FAIL to_err_clear: bus_err=%b, expected 0", bus_err);
      end
   endtask

   task automatic test_write_dominant();
      exp_t e;
      logic [31:0] din_before;
      apply_reset();
      mem_silent = 1'b0; mem_lat = 3;
      mem_ren = 1'b1; mem_addr = 32'h700;
      for (int i = 0; i < 12 && !mem_ack; i++) @(negedge clk);
      mem_ren = 1'b0;
      din_before = mem_word(32'h700);
      n_checks++;
      if (mem_din !== din_before) begin
         n_errors++;
         $display("FAIL wd_prime: mem_din=%h, expected %h", mem_din, din_before);
      end
      @(negedge clk);
      sb.push_back(mk(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0));
      mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h100; mem_dout = 32'hDEADBEEF;
      @(negedge clk);
      e = sb[0];
      n_checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, e.addr, e.wdata}) begin
         n_errors++;
         $display("FAIL wd_bus: req=%b we=%b addr=%h wdata=%h, expected 1 1 %h %h",
                  bus_req, bus_we, bus_addr, bus_wdata, e.addr, e.wdata);
      end
      for (int i = 0; i < 12 && !mem_ack; i++) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (mem_ack !== 1'b1 || mem_din !== din_before || mem_stall !== 1'b0) begin
         n_errors++;
         $display("FAIL wd_ack: ack=%b din=%h stall=%b, expected 1 %h 0",
                  mem_ack, mem_din, mem_stall, din_before);
      end
      mem_ren = 1'b0; mem_wen = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_busy();
      bit seen;
      apply_reset();
      mem_silent = 1'b1;
      mem_addr = 32'h900; mem_ren = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (bus_req !== 1'b1) begin
         n_errors++;
         $display("FAIL rmb_busy: bus_req=%b, expected 1", bus_req);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({bus_req, mem_ack} !== 2'b00) begin
         n_errors++;
         $display("FAIL rmb_async: {req,ack}=%b, expected 00", {bus_req, mem_ack});
      end
      mem_ren = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; mem_silent = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (inst_ack || mem_ack || bus_req) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_errors++;
         $display("FAIL rmb_spurious: activity seen=%b after reset, expected 0", seen);
      end
      mem_lat = 1;
      inst_addr = 32'h40; inst_ren = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (inst_ack !== 1'b1 || inst_data !== mem_word(32'h40)) begin
         n_errors++;
         $display("FAIL rmb_idle_fetch: ack=%b data=%h, expected 1 %h", inst_ack, inst_data, mem_word(32'h40));
      end
      inst_ren = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stray_ack();
      bit seen;
      apply_reset();
      seen = 1'b0;
      stray_ack = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (inst_ack || mem_ack || bus_req) seen = 1'b1;
      end
      stray_ack = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (inst_ack || mem_ack || bus_req) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0 || {inst_data, mem_din} !== 64'h0) begin
         n_errors++;
         $display("FAIL stray_ack: activity=%b inst_data=%h mem_din=%h, expected 0 0 0",
                  seen, inst_data, mem_din);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_simultaneous();
      test_streak();
      test_timeout();
      test_write_dominant();
      test_reset_mid_busy();
      test_stray_ack();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
